// File: rtl/sound_arbiter.sv
// Fixed-priority scheduler of four sound sources onto one tone generator. Request to grant takes 1 cycle.
// Nothing can stall it: one-shot pulses wait in pending flags, and a silent gap follows every grant.
module sound_arbiter #(
   parameter int unsigned CLICK_CYCLES = 150_000,
   parameter int unsigned CHIME_CYCLES = 25_000_000,
   parameter int unsigned GAP_CYCLES   = 50_000,
   parameter int unsigned HORN_PERIOD  = 62_500,
   parameter int unsigned TICK_PERIOD  = 12_500,
   parameter int unsigned TOCK_PERIOD  = 15_625,
   parameter int unsigned CHIME_PERIOD = 28_409
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        engine_on,
   input  logic        horn_req,
   input  logic        click_req,
   input  logic        click_is_tick,
   input  logic        chime_req,
   input  logic        melody_req,
   input  logic [19:0] melody_period,
   output logic [19:0] tone_period,
   output logic        tone_en,
   output logic [3:0]  grant,
   output logic        busy,
   output logic        drop_pulse
);

   localparam logic [19:0] HORN_P  = 20'(HORN_PERIOD);
   localparam logic [19:0] TICK_P  = 20'(TICK_PERIOD);
   localparam logic [19:0] TOCK_P  = 20'(TOCK_PERIOD);
   localparam logic [19:0] CHIME_P = 20'(CHIME_PERIOD);
   localparam logic [31:0] CLICK_LOAD = 32'(CLICK_CYCLES - 1);
   localparam logic [31:0] CHIME_LOAD = 32'(CHIME_CYCLES - 1);
   localparam logic [31:0] GAP_LOAD   = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t      state;
   logic        click_pend;
   logic        chime_pend;
   logic        click_tick;
   logic [31:0] dur_cnt;
   logic [31:0] gap_cnt;

   logic [3:0]  elig;
   logic [3:0]  pick;
   logic        tick_eff;
   logic [19:0] click_p;
   logic        higher;
   logic        play_end;
   logic        play_drop;

   always_comb begin
      // Incoming pulses count as eligible so a request in cycle N is granted in N+1.
      elig      = {melody_req & engine_on, chime_pend | chime_req, click_pend | click_req, horn_req};
      pick      = elig & (~elig + 4'd1);
      tick_eff  = click_req ? click_is_tick : click_tick;
      click_p   = tick_eff ? TICK_P : TOCK_P;
      // grant is one-hot, so grant-1 masks exactly the higher-priority sources.
      higher    = |(elig & (grant - 4'd1));
      play_end  = 1'b0;
      play_drop = 1'b0;
      if (grant[0]) begin
         play_end = ~elig[0];
      end else if (grant[1] | grant[2]) begin
         play_end  = (dur_cnt == 32'd0) | higher;
         play_drop = (dur_cnt != 32'd0) & higher;
      end else if (grant[3]) begin
         play_end = ~elig[3] | higher;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         click_pend  <= 1'b0;
         chime_pend  <= 1'b0;
         click_tick  <= 1'b0;
         dur_cnt     <= 32'd0;
         gap_cnt     <= 32'd0;
         tone_period <= 20'd0;
         tone_en     <= 1'b0;
         grant       <= 4'd0;
         busy        <= 1'b0;
         drop_pulse  <= 1'b0;
      end else begin
         drop_pulse <= 1'b0;
         if (click_req) begin
            click_pend <= 1'b1;
            click_tick <= click_is_tick;
         end
         if (chime_req) chime_pend <= 1'b1;

         case (state)
            IDLE, GAP: begin
               if (state == GAP && gap_cnt != 32'd0) begin
                  gap_cnt <= gap_cnt - 32'd1;
               end else if (|elig) begin
                  state <= PLAY;
                  grant <= pick;
                  busy  <= 1'b1;
                  // A grant consumes the pending flag together with any pulse merged into it.
                  if (pick[0]) begin
                     tone_period <= HORN_P;
                     tone_en     <= (HORN_P != 20'd0);
                  end else if (pick[1]) begin
                     tone_period <= click_p;
                     tone_en     <= (click_p != 20'd0);
                     dur_cnt     <= CLICK_LOAD;
                     click_pend  <= 1'b0;
                  end else if (pick[2]) begin
                     tone_period <= CHIME_P;
                     tone_en     <= (CHIME_P != 20'd0);
                     dur_cnt     <= CHIME_LOAD;
                     chime_pend  <= 1'b0;
                  end else begin
                     tone_period <= melody_period;
                     tone_en     <= (melody_period != 20'd0);
                  end
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            PLAY: begin
               if (play_end) begin
                  state       <= GAP;
                  grant       <= 4'd0;
                  tone_period <= 20'd0;
                  tone_en     <= 1'b0;
                  gap_cnt     <= GAP_LOAD;
                  drop_pulse  <= play_drop;
               end else begin
                  if (dur_cnt != 32'd0) dur_cnt <= dur_cnt - 32'd1;
                  if (grant[3]) begin
                     tone_period <= melody_period;
                     tone_en     <= (melody_period != 20'd0);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
